// File: rtl/lsu_mem_stage.sv
// MEM-stage load/store unit: runs a dread/dwrite handshake with the D-cache, stalls the
// pipeline until dresp, then presents the aligned and extended load result.
module lsu_mem_stage #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned NBYTES = XLEN / 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              ex_valid_i,
    input  logic              ex_read_i,
    input  logic              ex_write_i,
    input  logic [2:0]        ex_funct3_i,
    input  logic [XLEN-1:0]   ex_addr_i,
    input  logic [XLEN-1:0]   ex_wdata_i,
    output logic              stall_o,
    output logic              dread_o,
    output logic              dwrite_o,
    output logic [XLEN-1:0]   daddr_o,
    output logic [XLEN-1:0]   dwdata_o,
    output logic [NBYTES-1:0] dmbe_o,
    input  logic              dresp_i,
    input  logic [XLEN-1:0]   drdata_i,
    output logic              wb_valid_o,
    output logic [XLEN-1:0]   wb_data_o,
    output logic              fault_o
);

    localparam int unsigned OffW = $clog2(NBYTES);

    typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

    state_e            state_q, state_d;
    logic              dread_q, dread_d;
    logic              dwrite_q, dwrite_d;
    logic [XLEN-1:0]   daddr_q, daddr_d;
    logic [XLEN-1:0]   dwdata_q, dwdata_d;
    logic [NBYTES-1:0] dmbe_q, dmbe_d;
    logic [XLEN-1:0]   wb_data_q, wb_data_d;
    logic              fault_q, fault_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [OffW-1:0]   offset_q, offset_d;
    logic              is_load_q, is_load_d;

    logic              req, accept, unsupported, misaligned;
    logic [OffW-1:0]   offset;
    logic [NBYTES-1:0] mask_base;
    logic [XLEN-1:0]   rshift, lmask, load_ext;
    logic              lsign;

    assign offset = ex_addr_i[OffW-1:0];
    assign req    = ex_valid_i & (ex_read_i ^ ex_write_i);

    // Doublewords do not fit a 32-bit word; lwu and an unsigned 8-byte load have no meaning.
    assign unsupported = ((ex_funct3_i[1:0] == 2'b11) && (NBYTES < 8))
                       | ((XLEN == 32) && (ex_funct3_i == 3'b110))
                       | (!ex_write_i && (ex_funct3_i == 3'b111));

    always_comb begin
        misaligned = 1'b0;
        mask_base  = '0;
        unique case (ex_funct3_i[1:0])
            2'b00: begin
                misaligned = 1'b0;
                mask_base  = NBYTES'(1);
            end
            2'b01: begin
                misaligned = ex_addr_i[0];
                mask_base  = NBYTES'(3);
            end
            2'b10: begin
                misaligned = |ex_addr_i[1:0];
                mask_base  = NBYTES'(15);
            end
            default: begin
                misaligned = |ex_addr_i[2:0];
                mask_base  = NBYTES'(8'hFF);
            end
        endcase
    end

    assign accept = (state_q == StIdle) & req & ~unsupported & ~misaligned;

    // Load extraction: shift the addressed lane down, then truncate and extend by size.
    assign rshift = drdata_i >> {offset_q, 3'b000};

    always_comb begin
        lmask = '1;
        lsign = 1'b0;
        unique case (funct3_q[1:0])
            2'b00: begin
                lmask = XLEN'(8'hFF);
                lsign = rshift[7];
            end
            2'b01: begin
                lmask = XLEN'(16'hFFFF);
                lsign = rshift[15];
            end
            2'b10: begin
                lmask = XLEN'(32'hFFFF_FFFF);
                lsign = rshift[31];
            end
            default: begin
                lmask = '1;
                lsign = rshift[XLEN-1];
            end
        endcase
        load_ext = (rshift & lmask) | ({XLEN{lsign & ~funct3_q[2]}} & ~lmask);
    end

    always_comb begin
        state_d   = state_q;
        dread_d   = dread_q;
        dwrite_d  = dwrite_q;
        daddr_d   = daddr_q;
        dwdata_d  = dwdata_q;
        dmbe_d    = dmbe_q;
        wb_data_d = wb_data_q;
        fault_d   = 1'b0;
        funct3_d  = funct3_q;
        offset_d  = offset_q;
        is_load_d = is_load_q;
        unique case (state_q)
            StIdle: begin
                fault_d = ex_valid_i & ((ex_read_i & ex_write_i)
                                        | (req & (unsupported | misaligned)));
                if (accept) begin
                    state_d   = StReq;
                    dread_d   = ex_read_i;
                    dwrite_d  = ex_write_i;
                    daddr_d   = {ex_addr_i[XLEN-1:OffW], {OffW{1'b0}}};
                    dwdata_d  = ex_write_i ? (ex_wdata_i << {offset, 3'b000}) : '0;
                    dmbe_d    = ex_write_i ? (mask_base << offset) : '0;
                    funct3_d  = ex_funct3_i;
                    offset_d  = offset;
                    is_load_d = ex_read_i;
                end
            end
            StReq: begin
                if (dresp_i) begin
                    state_d  = StDone;
                    dread_d  = 1'b0;
                    dwrite_d = 1'b0;
                    if (is_load_q) begin
                        wb_data_d = load_ext;
                    end
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            dread_q   <= 1'b0;
            dwrite_q  <= 1'b0;
            daddr_q   <= '0;
            dwdata_q  <= '0;
            dmbe_q    <= '0;
            wb_data_q <= '0;
            fault_q   <= 1'b0;
            funct3_q  <= '0;
            offset_q  <= '0;
            is_load_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            dread_q   <= dread_d;
            dwrite_q  <= dwrite_d;
            daddr_q   <= daddr_d;
            dwdata_q  <= dwdata_d;
            dmbe_q    <= dmbe_d;
            wb_data_q <= wb_data_d;
            fault_q   <= fault_d;
            funct3_q  <= funct3_d;
            offset_q  <= offset_d;
            is_load_q <= is_load_d;
        end
    end

    // Gated by reset so a held EX/MEM instruction cannot stall the pipe while in reset.
    assign stall_o    = ~rst_i & (accept | (state_q == StReq));
    assign dread_o    = dread_q;
    assign dwrite_o   = dwrite_q;
    assign daddr_o    = daddr_q;
    assign dwdata_o   = dwdata_q;
    assign dmbe_o     = dmbe_q;
    assign wb_valid_o = (state_q == StDone) & is_load_q;
    assign wb_data_o  = wb_data_q;
    assign fault_o    = fault_q;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Bench for lsu_mem_stage: 32- and 64-bit instances share stimulus, a select picks the one
// under test; vector table plus hand sequences, load results checked through a scoreboard.
module tb_lsu_mem_stage;

    localparam int KLoad  = 0;
    localparam int KStore = 1;
    localparam int KFault = 2;
    localparam int KNone  = 3;

    typedef struct {
        bit          sel64;
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] rdata;
        int          delay;
        int          kind;
        logic [63:0] e_daddr;
        logic [7:0]  e_dmbe;
        logic [63:0] e_dwdata;
        logic [63:0] e_wb;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    bit          sel64 = 1'b0;
    bit          keep_resp = 1'b0;
    logic        ex_valid = 1'b0;
    logic        ex_read = 1'b0;
    logic        ex_write = 1'b0;
    logic [2:0]  ex_funct3 = 3'b000;
    logic [63:0] ex_addr = '0;
    logic [63:0] ex_wdata = '0;
    logic        dresp = 1'b0;
    logic [63:0] drdata = '0;

    logic        stall32, dread32, dwrite32, wb_valid32, fault32;
    logic [31:0] daddr32, dwdata32, wb_data32;
    logic [3:0]  dmbe32;
    logic        stall64, dread64, dwrite64, wb_valid64, fault64;
    logic [63:0] daddr64, dwdata64, wb_data64;
    logic [7:0]  dmbe64;

    logic        stall_m, dread_m, dwrite_m, wb_valid_m, fault_m;
    logic [63:0] daddr_m, dwdata_m, wb_data_m;
    logic [7:0]  dmbe_m;

    int          n_vec = 0;
    int          n_fail = 0;
    logic [63:0] sb_q[$];
    vec_t        tbl[$];

    always #5 clk = ~clk;

    lsu_mem_stage #(.XLEN(32)) dut32 (
        .clk_i      (clk),
        .rst_i      (rst),
        .ex_valid_i (ex_valid & !sel64),
        .ex_read_i  (ex_read),
        .ex_write_i (ex_write),
        .ex_funct3_i(ex_funct3),
        .ex_addr_i  (ex_addr[31:0]),
        .ex_wdata_i (ex_wdata[31:0]),
        .stall_o    (stall32),
        .dread_o    (dread32),
        .dwrite_o   (dwrite32),
        .daddr_o    (daddr32),
        .dwdata_o   (dwdata32),
        .dmbe_o     (dmbe32),
        .dresp_i    (dresp & !sel64),
        .drdata_i   (drdata[31:0]),
        .wb_valid_o (wb_valid32),
        .wb_data_o  (wb_data32),
        .fault_o    (fault32)
    );

    lsu_mem_stage #(.XLEN(64)) dut64 (
        .clk_i      (clk),
        .rst_i      (rst),
        .ex_valid_i (ex_valid & sel64),
        .ex_read_i  (ex_read),
        .ex_write_i (ex_write),
        .ex_funct3_i(ex_funct3),
        .ex_addr_i  (ex_addr),
        .ex_wdata_i (ex_wdata),
        .stall_o    (stall64),
        .dread_o    (dread64),
        .dwrite_o   (dwrite64),
        .daddr_o    (daddr64),
        .dwdata_o   (dwdata64),
        .dmbe_o     (dmbe64),
        .dresp_i    (dresp & sel64),
        .drdata_i   (drdata),
        .wb_valid_o (wb_valid64),
        .wb_data_o  (wb_data64),
        .fault_o    (fault64)
    );

    always_comb begin
        stall_m    = sel64 ? stall64    : stall32;
        dread_m    = sel64 ? dread64    : dread32;
        dwrite_m   = sel64 ? dwrite64   : dwrite32;
        wb_valid_m = sel64 ? wb_valid64 : wb_valid32;
        fault_m    = sel64 ? fault64    : fault32;
        daddr_m    = sel64 ? daddr64    : {32'b0, daddr32};
        dwdata_m   = sel64 ? dwdata64   : {32'b0, dwdata32};
        wb_data_m  = sel64 ? wb_data64  : {32'b0, wb_data32};
        dmbe_m     = sel64 ? dmbe64     : {4'b0, dmbe32};
    end

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        check64(name, {63'b0, act}, {63'b0, exp});
    endtask

    function automatic vec_t mk(input bit s, input logic rd, input logic wr,
                                input logic [2:0] f3, input logic [63:0] addr,
                                input logic [63:0] wdata, input logic [63:0] rdata,
                                input int delay, input int kind, input logic [63:0] ea,
                                input logic [7:0] em, input logic [63:0] ed,
                                input logic [63:0] ew);
        vec_t v;
        v.sel64 = s;  v.rd = rd;  v.wr = wr;  v.f3 = f3;
        v.addr = addr;  v.wdata = wdata;  v.rdata = rdata;
        v.delay = delay;  v.kind = kind;
        v.e_daddr = ea;  v.e_dmbe = em;  v.e_dwdata = ed;  v.e_wb = ew;
        return v;
    endfunction

    // Scoreboard: every wb_valid pulse must match the oldest outstanding load.
    always @(negedge clk) begin
        if (!rst && wb_valid_m) begin
            if (sb_q.size() == 0) begin
                check1("wb_unexpected", wb_valid_m, 1'b0);
            end else begin
                check64("wb_data", wb_data_m, sb_q.pop_front());
            end
        end
    end

    task automatic run_vec(input vec_t v);
        @(negedge clk);
        check1("idle_no_dread", dread_m, 1'b0);
        check1("idle_no_dwrite", dwrite_m, 1'b0);
        check1("idle_no_fault", fault_m, 1'b0);
        sel64     = v.sel64;
        ex_valid  = 1'b1;
        ex_read   = v.rd;
        ex_write  = v.wr;
        ex_funct3 = v.f3;
        ex_addr   = v.addr;
        ex_wdata  = v.wdata;
        drdata    = v.rdata;
        dresp     = keep_resp;
        #1;
        check1("accept_stall", stall_m, (v.kind == KLoad) || (v.kind == KStore));
        if (v.kind == KLoad) sb_q.push_back(v.e_wb);
        @(negedge clk);
        if (v.kind == KFault || v.kind == KNone) begin
            check1("fault_pulse", fault_m, v.kind == KFault);
            check1("fault_no_dread", dread_m, 1'b0);
            check1("fault_no_dwrite", dwrite_m, 1'b0);
            check1("fault_no_stall", stall_m, 1'b0);
            ex_valid = 1'b0;
        end else begin
            check1("req_dread", dread_m, v.rd);
            check1("req_dwrite", dwrite_m, v.wr);
            check64("req_daddr", daddr_m, v.e_daddr);
            check64("req_dmbe", {56'b0, dmbe_m}, {56'b0, v.e_dmbe});
            if (v.kind == KStore) check64("req_dwdata", dwdata_m, v.e_dwdata);
            for (int i = 0; i < v.delay; i++) begin
                check1("req_wait_stall", stall_m, 1'b1);
                @(negedge clk);
            end
            dresp = 1'b1;
            check1("req_resp_stall", stall_m, 1'b1);
            @(negedge clk);
            dresp = keep_resp;
            check1("done_stall", stall_m, 1'b0);
            check1("done_dread", dread_m, 1'b0);
            check1("done_dwrite", dwrite_m, 1'b0);
            check1("done_wb_valid", wb_valid_m, v.kind == KLoad);
        end
    endtask

    initial begin
        // XLEN=32
        tbl.push_back(mk(0, 1'b1, 1'b0, 3'b000, 64'h1003, 64'h0, 64'h80FF_1234, 1, KLoad,
                         64'h1000, 8'h00, 64'h0, 64'hFFFF_FF80));
        tbl.push_back(mk(0, 1'b1, 1'b0, 3'b100, 64'h1003, 64'h0, 64'h80FF_1234, 1, KLoad,
                         64'h1000, 8'h00, 64'h0, 64'h0000_0080));
        tbl.push_back(mk(0, 1'b0, 1'b1, 3'b001, 64'h2002, 64'h0000_ABCD, 64'h0, 0, KStore,
                         64'h2000, 8'h0C, 64'hABCD_0000, 64'h0));
        tbl.push_back(mk(0, 1'b1, 1'b0, 3'b010, 64'h3001, 64'h0, 64'h0, 0, KFault,
                         64'h0, 8'h00, 64'h0, 64'h0));
        tbl.push_back(mk(0, 1'b1, 1'b0, 3'b011, 64'h3000, 64'h0, 64'h0, 0, KFault,
                         64'h0, 8'h00, 64'h0, 64'h0));
        tbl.push_back(mk(0, 1'b1, 1'b1, 3'b010, 64'h3000, 64'h0, 64'h0, 0, KFault,
                         64'h0, 8'h00, 64'h0, 64'h0));
        tbl.push_back(mk(0, 1'b0, 1'b0, 3'b010, 64'h3000, 64'h0, 64'h0, 0, KNone,
                         64'h0, 8'h00, 64'h0, 64'h0));
        tbl.push_back(mk(0, 1'b1, 1'b0, 3'b001, 64'h2006, 64'h0, 64'h8001_7FFF, 2, KLoad,
                         64'h2004, 8'h00, 64'h0, 64'hFFFF_8001));
        tbl.push_back(mk(0, 1'b1, 1'b0, 3'b101, 64'h2002, 64'h0, 64'h8001_0000, 0, KLoad,
                         64'h2000, 8'h00, 64'h0, 64'h0000_8001));
        tbl.push_back(mk(0, 1'b0, 1'b1, 3'b000, 64'h5001, 64'h1234_5678, 64'h0, 1, KStore,
                         64'h5000, 8'h02, 64'h3456_7800, 64'h0));
        // XLEN=64
        tbl.push_back(mk(1, 1'b1, 1'b0, 3'b011, 64'h4008, 64'h0, 64'h8000_0000_0000_0001, 1,
                         KLoad, 64'h4008, 8'h00, 64'h0, 64'h8000_0000_0000_0001));
        tbl.push_back(mk(1, 1'b1, 1'b0, 3'b110, 64'h400C, 64'h0, 64'hF000_0000_1234_5678, 0,
                         KLoad, 64'h4008, 8'h00, 64'h0, 64'h0000_0000_F000_0000));
        tbl.push_back(mk(1, 1'b1, 1'b0, 3'b010, 64'h400C, 64'h0, 64'hF000_0000_1234_5678, 0,
                         KLoad, 64'h4008, 8'h00, 64'h0, 64'hFFFF_FFFF_F000_0000));
        tbl.push_back(mk(1, 1'b0, 1'b1, 3'b011, 64'h6000, 64'h1122_3344_5566_7788, 64'h0, 0,
                         KStore, 64'h6000, 8'hFF, 64'h1122_3344_5566_7788, 64'h0));
        tbl.push_back(mk(1, 1'b0, 1'b1, 3'b010, 64'h6004, 64'hAABB_CCDD, 64'h0, 0,
                         KStore, 64'h6000, 8'hF0, 64'hAABB_CCDD_0000_0000, 64'h0));
        tbl.push_back(mk(1, 1'b1, 1'b0, 3'b001, 64'h6003, 64'h0, 64'h0, 0, KFault,
                         64'h0, 8'h00, 64'h0, 64'h0));
        tbl.push_back(mk(1, 1'b1, 1'b0, 3'b111, 64'h6000, 64'h0, 64'h0, 0, KFault,
                         64'h0, 8'h00, 64'h0, 64'h0));
        tbl.push_back(mk(1, 1'b1, 1'b0, 3'b000, 64'h7005, 64'h0, 64'h0000_7F00_0000_0000, 1,
                         KLoad, 64'h7000, 8'h00, 64'h0, 64'h0000_0000_0000_007F));
        tbl.push_back(mk(1, 1'b1, 1'b0, 3'b000, 64'h7006, 64'h0, 64'h00FE_0000_0000_0000, 0,
                         KLoad, 64'h7000, 8'h00, 64'h0, 64'hFFFF_FFFF_FFFF_FFFE));

        @(negedge clk);
        check1("rst_stall", stall_m, 1'b0);
        check1("rst_dread", dread_m, 1'b0);
        check1("rst_dwrite", dwrite_m, 1'b0);
        check1("rst_wb_valid", wb_valid_m, 1'b0);
        check1("rst_fault", fault_m, 1'b0);
        check64("rst_daddr", daddr_m, 64'h0);
        check64("rst_dwdata", dwdata_m, 64'h0);
        check64("rst_dmbe", {56'b0, dmbe_m}, 64'h0);
        check64("rst_wb_data", wb_data_m, 64'h0);
        rst = 1'b0;

        foreach (tbl[i]) run_vec(tbl[i]);

        // Back-to-back load then store with dresp held high throughout.
        keep_resp = 1'b1;
        run_vec(mk(0, 1'b1, 1'b0, 3'b010, 64'h104, 64'h0, 64'hCAFE_F00D, 0, KLoad,
                   64'h104, 8'h00, 64'h0, 64'hCAFE_F00D));
        run_vec(mk(0, 1'b0, 1'b1, 3'b010, 64'h108, 64'h0102_0304, 64'h0, 0, KStore,
                   64'h108, 8'h0F, 64'h0102_0304, 64'h0));
        keep_resp = 1'b0;

        // Spurious dresp while idle.
        @(negedge clk);
        ex_valid = 1'b0;
        dresp    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check1("spur_wb_valid", wb_valid_m, 1'b0);
            check1("spur_dread", dread_m, 1'b0);
            check1("spur_stall", stall_m, 1'b0);
        end
        dresp = 1'b0;

        // Reset in the middle of a read request.
        @(negedge clk);
        sel64     = 1'b0;
        ex_valid  = 1'b1;
        ex_read   = 1'b1;
        ex_write  = 1'b0;
        ex_funct3 = 3'b010;
        ex_addr   = 64'h3000;
        @(negedge clk);
        check1("midreq_dread", dread_m, 1'b1);
        #2 rst = 1'b1;
        #1;
        check1("midrst_dread", dread_m, 1'b0);
        check1("midrst_stall", stall_m, 1'b0);
        check1("midrst_wb_valid", wb_valid_m, 1'b0);
        @(negedge clk);
        ex_valid = 1'b0;
        rst      = 1'b0;
        run_vec(mk(0, 1'b1, 1'b0, 3'b010, 64'h100, 64'h0, 64'hDEAD_BEEF, 1, KLoad,
                   64'h100, 8'h00, 64'h0, 64'hDEAD_BEEF));

        @(negedge clk);
        ex_valid = 1'b0;
        @(negedge clk);
        check64("sb_drained", 64'(sb_q.size()), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu_mem_stage.md
Name: lsu_mem_stage

Overview:
- Parametrised load/store unit for the MEM stage of the pipelined rv32i core; successor to the always-loading, single-cycle memory path.
- Accepts one memory op from the EX/MEM pipeline register and runs a dread/dwrite handshake with the D-cache.
- Stalls the pipeline until the cache sees dresp, then presents the aligned and extended load result for writeback.
- Generalised to XLEN 32/64. Adds byte-mask generation, store lane steering and fault detection; the earlier path has none of these.

Parameters:
- XLEN, 32, datapath and cache word width; legal values 32 or 64.
- NBYTES, XLEN/8, byte lanes per word (derived; do not override).

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- ex_valid  in  1  EX/MEM register holds a valid instruction
- ex_read  in  1  instruction is a load
- ex_write  in  1  instruction is a store
- ex_funct3  in  3  RISC-V funct3 (size/sign)
- ex_addr  in  XLEN  byte address
- ex_wdata  in  XLEN  store data, low-aligned
- stall  out  1  freeze PC and all pipeline registers
- dread  out  1  D-cache read request
- dwrite  out  1  D-cache write request
- daddr  out  XLEN  word-aligned address (low log2(NBYTES) bits zero)
- dwdata  out  XLEN  lane-steered store data
- dmbe  out  NBYTES  byte enables (write only; zero on reads)
- dresp  in  1  D-cache response / done
- drdata  in  XLEN  D-cache read word
- wb_valid  out  1  one-cycle pulse: wb_data valid for the completed load
- wb_data  out  XLEN  extended load result
- fault  out  1  one-cycle pulse: misaligned or unsupported access dropped

Behaviour:
- Reset (async, any state): state=IDLE. stall, dread, dwrite, wb_valid and fault are 0. daddr, dwdata, dmbe and wb_data are 0. Any in-flight cache transaction is abandoned.
- States: IDLE, REQ, DONE.
- Request condition `req` = ex_valid & (ex_read ^ ex_write), in IDLE only.
- Legality: size = 1, 2, 4 or 8 bytes from funct3[1:0].
  - Unsupported: funct3 011 or 110 when XLEN=32; funct3[1:0]=11 with ex_write=0 and funct3[2]=1; ex_read&ex_write both high with ex_valid.
  - Misaligned: (ex_addr mod size) != 0.
- IDLE, legal request: stall asserted combinationally that cycle. Latch daddr, dwdata, dmbe, direction, funct3 and offset. Go to REQ.
- IDLE, illegal or misaligned request: fault=1 next cycle (registered, one-cycle pulse). No cache access, stall not asserted. Stay in IDLE.
- REQ: dread or dwrite held high, stall=1; all d* outputs stable until dresp.
  - dresp=1: capture the extended drdata into wb_data (loads only), deassert dread/dwrite the next cycle, go to DONE.
- DONE: stall=0, wb_valid=1 for loads only (stores: wb_valid=0). Go to IDLE unconditionally.
  - ex_valid in DONE is ignored; the same instruction is still in EX/MEM.
- Latency: request accepted cycle N, dread high from N+1. With dresp at cycle M, wb_valid at M+1. Minimum 3 cycles per memory op (dresp at N+1).
- Store steering: offset = ex_addr mod NBYTES. dmbe = ((1<<size)-1) << offset. dwdata = ex_wdata << (8*offset).
- Load extraction: word = drdata >> (8*offset), truncated to size.
  - Sign-extended for funct3[2]=0.
  - Zero-extended for funct3[2]=1 (lbu, lhu, lwu).
- dresp outside REQ is ignored.
- Non-memory ex_valid instructions: no stall, no outputs.

Test Plan:
- Reset mid-REQ: assert rst while dread=1 → dread, stall and wb_valid drop to 0 in the same cycle; state IDLE. After release, a new lw at 0x100 issues normally.
- XLEN=32, lb at ex_addr=0x1003, drdata=0x80FF_1234, dresp on the 2nd REQ cycle → daddr=0x1000, stall high 3 cycles, then wb_valid with wb_data=0xFFFF_FF80. Repeat as lbu → 0x0000_0080.
- XLEN=32, sh at 0x2002, ex_wdata=0x0000_ABCD → dwrite=1, daddr=0x2000, dmbe=4'b1100, dwdata=0xABCD_0000. After dresp, DONE has wb_valid=0.
- XLEN=32, lw at 0x3001 → fault pulse 1 cycle, dread never asserted, stall stays 0. funct3=011 at XLEN=32 → fault.
- XLEN=64, ld at 0x4008, drdata=0x8000_0000_0000_0001 → dmbe=0 on the read, wb_data=0x8000_0000_0000_0001. lwu at 0x400C with drdata=0xF000_0000_1234_5678 → 0x0000_0000_F000_0000.
- Back-to-back: lw then sw presented on consecutive accepted cycles, dresp held high → both complete. A spurious dresp in IDLE causes no wb_valid, and ex_valid in DONE causes no re-issue.
